// File: rtl/led_debug_monitor.sv
// Purpose : drives the board LEDs from a runtime-selected debug source (static
//           pattern, stretched CPU phase strobes + heartbeat, paged data
//           snapshot, or a free-running activity counter).
// Latency : 1 cycle from MODE/PATTERN/internal state to the registered LED.
// Backpressure: none; every input is sampled each cycle and the LEDs always update.
//
// Ports:
//   CLK       system clock
//   RESET     synchronous active-high reset, overrides every other input
//   MODE      0 static, 1 phase strobes, 2 data page, 3 activity counter
//   PATTERN   LED pattern shown in mode 0
//   PHASE     single-cycle strobes: [0] T0, [1] T1, [2] EXECUTE, [3] SETWRITE
//   DATA_IN   data word to monitor
//   DATA_VLD  load DATA_IN into the snapshot register this cycle
//   LED       registered LED drive
//   PAGE      index of the snapshot page currently selected in mode 2
module led_debug_monitor #(
   parameter int LED_W       = 8,
   parameter int DATA_W      = 16,
   parameter int STRETCH_CYC = 2500000,
   parameter int PAGE_CYC    = 25000000,
   parameter int HB_CYC      = 12500000,
   localparam int NPAGES     = (DATA_W + LED_W - 1) / LED_W,
   localparam int PAGE_W     = (NPAGES > 1) ? $clog2(NPAGES) : 1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [1:0]        MODE,
   input  logic [LED_W-1:0]  PATTERN,
   input  logic [3:0]        PHASE,
   input  logic [DATA_W-1:0] DATA_IN,
   input  logic              DATA_VLD,
   output logic [LED_W-1:0]  LED,
   output logic [PAGE_W-1:0] PAGE
);

   localparam int SC_W = $clog2(STRETCH_CYC + 1);
   localparam int HB_W = (HB_CYC > 1) ? $clog2(HB_CYC) : 1;
   localparam int PS_W = (PAGE_CYC > 1) ? $clog2(PAGE_CYC) : 1;

   localparam logic [1:0] MODE_STATIC = 2'd0;
   localparam logic [1:0] MODE_PHASE  = 2'd1;
   localparam logic [1:0] MODE_PAGE   = 2'd2;
   localparam logic [1:0] MODE_COUNT  = 2'd3;

   logic [SC_W-1:0]         stretch_cnt [4];
   logic [3:0]              stretched;
   logic [HB_W-1:0]         hb_cnt;
   logic                    hb;
   logic [DATA_W-1:0]       act_cnt;
   logic [DATA_W-1:0]       snapshot;
   logic [1:0]              mode_q;
   logic [PS_W-1:0]         page_ps;
   logic [PAGE_W-1:0]       page_q;
   logic [NPAGES*LED_W-1:0] snap_pad;
   logic [LED_W-1:0]        page_word;
   logic [LED_W-1:0]        led_d;

   // Phase stretchers: a strobe (re)loads the full count, so a re-trigger
   // restarts the window rather than extending it cumulatively.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < 4; i++) stretch_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (PHASE[i])
               stretch_cnt[i] <= SC_W'(STRETCH_CYC);
            else if (stretch_cnt[i] != '0)
               stretch_cnt[i] <= stretch_cnt[i] - SC_W'(1);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) stretched[i] = (stretch_cnt[i] != '0);
   end

   // Heartbeat toggles once per HB_CYC cycles, independent of MODE.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         hb_cnt <= '0;
         hb     <= 1'b0;
      end else if (hb_cnt == HB_W'(HB_CYC - 1)) begin
         hb_cnt <= '0;
         hb     <= ~hb;
      end else begin
         hb_cnt <= hb_cnt + HB_W'(1);
      end
   end

   // Free-running activity counter, snapshot capture and previous-mode register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         act_cnt  <= '0;
         snapshot <= '0;
         mode_q   <= MODE_STATIC;
      end else begin
         act_cnt <= act_cnt + DATA_W'(1);
         mode_q  <= MODE;
         if (DATA_VLD) snapshot <= DATA_IN;
      end
   end

   // Page prescaler only runs while mode 2 is held steady; entering mode 2
   // (or leaving it) always restarts from page 0.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         page_ps <= '0;
         page_q  <= '0;
      end else if (MODE != MODE_PAGE || MODE != mode_q) begin
         page_ps <= '0;
         page_q  <= '0;
      end else if (page_ps == PS_W'(PAGE_CYC - 1)) begin
         page_ps <= '0;
         if (page_q == PAGE_W'(NPAGES - 1))
            page_q <= '0;
         else
            page_q <= page_q + PAGE_W'(1);
      end else begin
         page_ps <= page_ps + PS_W'(1);
      end
   end

   // Zero-extend the snapshot to a whole number of pages so the top page
   // reads unused bits as 0.
   always_comb begin
      snap_pad                = '0;
      snap_pad[DATA_W-1:0]    = snapshot;
      page_word               = '0;
      for (int p = 0; p < NPAGES; p++) begin
         if (page_q == PAGE_W'(p)) page_word = snap_pad[p*LED_W +: LED_W];
      end
   end

   always_comb begin
      led_d = '0;
      unique case (MODE)
         MODE_STATIC: led_d = PATTERN;
         MODE_PHASE: begin
            led_d[3:0]       = stretched;
            led_d[LED_W-1]   = hb;
         end
         MODE_PAGE:   led_d = page_word;
         MODE_COUNT:  led_d = act_cnt[DATA_W-1 -: LED_W];
         default:     led_d = '0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET)
         LED <= '0;
      else
         LED <= led_d;
   end

   assign PAGE = page_q;

endmodule

// File: tb/tb_led_debug_monitor.sv
module tb_led_debug_monitor;
   localparam int LED_W       = 8;
   localparam int DATA_W      = 16;
   localparam int STRETCH_CYC = 4;
   localparam int PAGE_CYC    = 8;
   localparam int HB_CYC      = 16;
   localparam int NPAGES      = 2;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [1:0]  MODE;
   logic [7:0]  PATTERN;
   logic [3:0]  PHASE;
   logic [15:0] DATA_IN;
   logic        DATA_VLD;
   logic [7:0]  LED;
   logic [0:0]  PAGE;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   led_debug_monitor #(
      .LED_W(LED_W), .DATA_W(DATA_W), .STRETCH_CYC(STRETCH_CYC),
      .PAGE_CYC(PAGE_CYC), .HB_CYC(HB_CYC)
   ) dut (
      .CLK(CLK), .RESET(RESET), .MODE(MODE), .PATTERN(PATTERN),
      .PHASE(PHASE), .DATA_IN(DATA_IN), .DATA_VLD(DATA_VLD),
      .LED(LED), .PAGE(PAGE)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: outputs derived from elapsed edges since reset, the
   // edge of each bit's most recent strobe, and how long mode 2 has been held.
   int          m_t;
   int          m_last [4];
   bit          m_have [4];
   logic [15:0] m_snap;
   logic [1:0]  m_prev_mode;
   int          m_run;
   int          m_p;
   logic [7:0]  m_l;
   logic [7:0]  exp_led;
   int          exp_page;
   bit          model_vld = 1'b0;

   always @(posedge CLK) begin
      if (RESET) begin
         m_t = 0;
         for (int i = 0; i < 4; i++) begin m_have[i] = 1'b0; m_last[i] = 0; end
         m_snap = '0;
         m_prev_mode = 2'd0;
         m_run = 0;
         exp_led = '0;
         exp_page = 0;
      end else begin
         m_l = '0;
         case (MODE)
            2'd0: m_l = PATTERN;
            2'd1: begin
               for (int i = 0; i < 4; i++)
                  if (m_have[i] && (m_t - m_last[i]) < STRETCH_CYC) m_l[i] = 1'b1;
               m_l[7] = ((m_t / HB_CYC) % 2) == 1;
            end
            2'd2: begin
               m_p = (m_run / PAGE_CYC) % NPAGES;
               m_l = m_snap[8*m_p +: 8];
            end
            default: m_l = 8'((m_t % 65536) / 256);
         endcase
         m_t++;
         for (int i = 0; i < 4; i++)
            if (PHASE[i]) begin m_have[i] = 1'b1; m_last[i] = m_t; end
         if (DATA_VLD) m_snap = DATA_IN;
         if (MODE == 2'd2 && m_prev_mode == 2'd2) m_run++;
         else m_run = 0;
         m_prev_mode = MODE;
         exp_led = m_l;
         exp_page = (m_run / PAGE_CYC) % NPAGES;
      end
      model_vld = 1'b1;
   end

   always @(negedge CLK) begin
      if (model_vld) begin
         check("model_led", LED, exp_led);
         check("model_page", PAGE, exp_page);
      end
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   int         cnt;
   int         n;
   logic       prev_b;
   logic [7:0] prev_v;
   logic [7:0] v;

   initial begin
      RESET = 1'b1; MODE = 2'd0; PATTERN = 8'hAA; PHASE = 4'h0;
      DATA_IN = 16'h0000; DATA_VLD = 1'b0;
      repeat (3) step();
      check("reset_led", LED, 8'h00);
      check("reset_page", PAGE, 0);
      RESET = 1'b0;
      step();
      check("static_aa", LED, 8'hAA);

      // Single strobe: exactly STRETCH_CYC cycles of LED[0].
      MODE = 2'd1;
      step(); step();
      PHASE = 4'b0001; step(); PHASE = 4'b0000;
      cnt = 0;
      repeat (10) begin step(); if (LED[0]) cnt++; end
      check("stretch_single", cnt, 4);

      // Re-trigger two edges after the first strobe: 2 + 4 cycles.
      cnt = 0;
      PHASE = 4'b0001; step(); if (LED[0]) cnt++;
      PHASE = 4'b0000; step(); if (LED[0]) cnt++;
      PHASE = 4'b0001; step(); if (LED[0]) cnt++;
      PHASE = 4'b0000;
      repeat (10) begin step(); if (LED[0]) cnt++; end
      check("stretch_retrigger", cnt, 6);

      // Heartbeat half-period on LED[7].
      prev_b = LED[7]; n = 0;
      while (LED[7] == prev_b && n < 40) begin step(); n++; end
      prev_b = LED[7]; n = 0;
      while (LED[7] == prev_b && n < 40) begin step(); n++; end
      check("hb_half_period", n, 16);

      // Data pages.
      MODE = 2'd2; DATA_IN = 16'h3CA5; DATA_VLD = 1'b1; step(); DATA_VLD = 1'b0;
      step();
      check("page0_led", LED, 8'hA5);
      check("page0_idx", PAGE, 0);
      repeat (7) step();
      check("page0_last_led", LED, 8'hA5);
      check("page1_idx", PAGE, 1);
      step();
      check("page1_led", LED, 8'h3C);
      repeat (7) step();
      check("page1_last_led", LED, 8'h3C);
      check("page_wrap_idx", PAGE, 0);
      step();
      check("page_wrap_led", LED, 8'hA5);
      repeat (8) step();
      check("page1_again", PAGE, 1);

      // Mode excursion restarts paging at page 0.
      MODE = 2'd0; PATTERN = 8'h0F; step();
      MODE = 2'd2; step();
      check("reenter_led", LED, 8'hA5);
      check("reenter_page", PAGE, 0);
      step();
      check("reenter_led2", LED, 8'hA5);

      // Capture while in mode 0 still updates the snapshot.
      MODE = 2'd0; DATA_IN = 16'h1234; DATA_VLD = 1'b1; step(); DATA_VLD = 1'b0;
      check("mode0_capture_led", LED, 8'h0F);
      MODE = 2'd2; step();
      check("mode0_capture_snap", LED, 8'h34);

      // Capture on the same edge as a page wrap.
      repeat (7) step();
      DATA_IN = 16'hBEEF; DATA_VLD = 1'b1; step(); DATA_VLD = 1'b0;
      step();
      check("vld_wrap_led", LED, 8'hBE);
      check("vld_wrap_page", PAGE, 1);

      // Reset while showing page 1.
      RESET = 1'b1; step();
      check("reset_p1_led", LED, 8'h00);
      check("reset_p1_page", PAGE, 0);

      // Reset mid-stretch leaves no residue.
      RESET = 1'b0; MODE = 2'd1; PHASE = 4'hF; step(); PHASE = 4'h0;
      step();
      check("pre_reset_stretch", LED[3:0], 4'hF);
      RESET = 1'b1; step();
      check("reset_stretch_led", LED, 8'h00);
      RESET = 1'b0; step();
      check("post_reset_stretch1", LED[3:0], 4'h0);
      step();
      check("post_reset_stretch2", LED[3:0], 4'h0);

      // Activity counter.
      MODE = 2'd3; step();
      prev_v = LED; n = 0;
      while (LED == prev_v && n < 300) begin step(); n++; end
      v = LED; n = 0;
      while (LED == v && n < 300) begin step(); n++; end
      check("act_period", n, 256);
      check("act_increment", LED, 32'(v + 8'd1));
      prev_v = LED; n = 0;
      while (!(LED == 8'h00 && prev_v == 8'hFF) && n < 70000) begin
         prev_v = LED; step(); n++;
      end
      check("act_wrap_seen", (n < 70000), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
